iso7816_3_card: RTL

Card-side ISO 7816-3 character engine: the responder at the far end of the `isoSio`/`isoClk`/`isoReset`/`isoVdd` link driven by the reader master. It follows card activation, enforces the minimum ATR delay, and moves bytes in both directions over the open-drain I/O line, all timed in `isoClk` cycles. Bytes use even parity, direct or inverse convention, and T=0 character-level error signalling and retransmission. A host (card OS model or test sequencer) feeds bytes to send and collects received bytes.

---
 rtl/iso7816_3_card.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/iso7816_3_card.sv
// Card-side ISO 7816-3 character engine: activation tracking, ATR delay, T=0 byte tx/rx with error signalling.
// Inputs react 3 clk after the contact changes; one holding register, host writes only while txReady is high.
module iso7816_3_card #(
    parameter int ATR_MIN_DELAY = 400,
    parameter int MAX_RETRY     = 4
) (
    input  logic        clk,
    input  logic        nReset,
    input  logic [12:0] cyclePerEtu,
    input  logic        useIndirectConvention,
    input  logic [7:0]  dataIn,
    input  logic        nWeDataIn,
    output logic [7:0]  dataOut,
    output logic        rxValid,
    output logic        rxParityError,
    output logic        txReady,
    output logic        txError,
    output logic        cardActive,
    output logic        atrReady,
    input  logic        isoVdd,
    input  logic        isoReset,
    input  logic        isoClk,
    inout  wire         isoSio
);

    localparam int AW = $clog2(ATR_MIN_DELAY + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);

    typedef enum logic [3:0] {
        S_OFF, S_WAIT_ATR, S_IDLE, S_TX, S_TX_GUARD, S_TX_NACK, S_RX, S_RX_END, S_RX_ERR
    } state_t;

    logic [1:0] vdd_sq, rst_sq, clk_sq, sio_sq;
    logic       clk_prev_q, sio_prev_q;

    state_t         state_q, state_d;
    logic [12:0]    sub_q, sub_d, etu_q, etu_d;
    logic [3:0]     idx_q, idx_d;
    logic           inv_q, inv_d;
    logic [AW-1:0]  atr_cnt_q, atr_cnt_d;
    logic           atr_ready_q, atr_ready_d;
    logic [7:0]     hold_q, hold_d, tx_byte_q, tx_byte_d, rx_sh_q, rx_sh_d, data_out_q, data_out_d;
    logic           hold_full_q, hold_full_d;
    logic [RW-1:0]  retry_q, retry_d;
    logic           drive_q, drive_d;
    logic           rx_valid_q, rx_valid_d, rx_perr_q, rx_perr_d, tx_error_q, tx_error_d;

    logic        powered, sio_s, iso_rise, sio_fall, etu_wrap, etu_mid, wr_en, start_char, rx_bit;
    logic [12:0] sub_inc, half_etu;
    logic [3:0]  idx_inc;

    // Line level for character bit n: 0 = start, 1..8 = data, 9 = parity.
    function automatic logic tx_level(input logic [7:0] b, input logic [3:0] n, input logic inv);
        logic       lv;
        logic [2:0] pos;
        pos = inv ? 3'(4'd8 - n) : 3'(n - 4'd1);
        if (n == 4'd0)      lv = 1'b0;
        else if (n == 4'd9) lv = ^b;
        else                lv = b[pos];
        return (n != 4'd0 && inv) ? ~lv : lv;
    endfunction

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            vdd_sq     <= '0;
            rst_sq     <= '0;
            clk_sq     <= '0;
            sio_sq     <= 2'b11;
            clk_prev_q <= 1'b0;
            sio_prev_q <= 1'b1;
        end else begin
            vdd_sq     <= {vdd_sq[0], isoVdd};
            rst_sq     <= {rst_sq[0], isoReset};
            clk_sq     <= {clk_sq[0], isoClk};
            sio_sq     <= {sio_sq[0], isoSio};
            clk_prev_q <= clk_sq[1];
            sio_prev_q <= sio_sq[1];
        end
    end

    assign powered  = vdd_sq[1] & rst_sq[1];
    assign sio_s    = sio_sq[1];
    assign iso_rise = clk_sq[1] & ~clk_prev_q;
    assign sio_fall = ~sio_s & sio_prev_q;
    assign sub_inc  = sub_q + 13'd1;
    assign half_etu = etu_q >> 1;
    assign idx_inc  = idx_q + 4'd1;
    assign etu_wrap = iso_rise && (sub_inc == etu_q);
    assign etu_mid  = iso_rise && (sub_inc == half_etu);
    assign rx_bit   = sio_s ^ inv_q;
    assign wr_en    = ~nWeDataIn & txReady;

    always_comb begin
        state_d     = state_q;
        sub_d       = sub_q;
        idx_d       = idx_q;
        etu_d       = etu_q;
        inv_d       = inv_q;
        atr_cnt_d   = atr_cnt_q;
        atr_ready_d = atr_ready_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_byte_d   = tx_byte_q;
        retry_d     = retry_q;
        rx_sh_d     = rx_sh_q;
        data_out_d  = data_out_q;
        drive_d     = drive_q;
        rx_valid_d  = 1'b0;
        rx_perr_d   = 1'b0;
        tx_error_d  = 1'b0;
        start_char  = 1'b0;

        if (wr_en) begin
            hold_d      = dataIn;
            hold_full_d = 1'b1;
        end
        if (iso_rise) begin
            if (etu_wrap) begin
                sub_d = '0;
                idx_d = idx_inc;
            end else begin
                sub_d = sub_inc;
            end
        end

        if (!powered) begin
            state_d     = S_OFF;
            drive_d     = 1'b0;
            hold_full_d = 1'b0;
            atr_ready_d = 1'b0;
            atr_cnt_d   = '0;
        end else begin
            case (state_q)
                S_OFF: begin
                    state_d   = S_WAIT_ATR;
                    atr_cnt_d = '0;
                end
                S_WAIT_ATR: if (iso_rise) begin
                    if (atr_cnt_q == AW'(ATR_MIN_DELAY - 1)) begin
                        state_d     = S_IDLE;
                        atr_ready_d = 1'b1;
                    end else begin
                        atr_cnt_d = atr_cnt_q + 1'b1;
                    end
                end
                // Reception wins over a pending byte; the byte goes out afterwards.
                S_IDLE: begin
                    if (sio_fall) begin
                        state_d    = S_RX;
                        start_char = 1'b1;
                    end else if (hold_full_q && iso_rise) begin
                        state_d     = S_TX;
                        tx_byte_d   = hold_q;
                        hold_full_d = 1'b0;
                        retry_d     = '0;
                        drive_d     = 1'b1;
                        start_char  = 1'b1;
                    end
                end
                S_TX: begin
                    if (etu_wrap) begin
                        if (idx_inc <= 4'd9) drive_d = ~tx_level(tx_byte_q, idx_inc, inv_q);
                        else                 drive_d = 1'b0;
                    end
                    if (etu_mid && idx_q == 4'd10) state_d = sio_s ? S_TX_GUARD : S_TX_NACK;
                end
                S_TX_GUARD: if (etu_wrap && idx_inc == 4'd12) state_d = S_IDLE;
                S_TX_NACK: if (etu_wrap && idx_inc == 4'd13) begin
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d    = retry_q + 1'b1;
                        state_d    = S_TX;
                        drive_d    = 1'b1;
                        start_char = 1'b1;
                    end else begin
                        tx_error_d = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
                S_RX: if (etu_mid) begin
                    if (idx_q == 4'd0) begin
                        if (sio_s) state_d = S_IDLE;
                    end else if (idx_q <= 4'd8) begin
                        rx_sh_d = inv_q ? {rx_sh_q[6:0], rx_bit} : {rx_bit, rx_sh_q[7:1]};
                    end else if (((^rx_sh_q) ^ rx_bit) == 1'b0) begin
                        data_out_d = rx_sh_q;
                        rx_valid_d = 1'b1;
                        state_d    = S_RX_END;
                    end else begin
                        rx_perr_d = 1'b1;
                        state_d   = S_RX_ERR;
                    end
                end
                S_RX_END: if (etu_mid && idx_q == 4'd10) state_d = S_IDLE;
                S_RX_ERR: begin
                    if (etu_mid && idx_q == 4'd10) drive_d = 1'b1;
                    if (etu_mid && idx_q == 4'd11) drive_d = 1'b0;
                    if (etu_wrap && idx_inc == 4'd12) state_d = S_IDLE;
                end
                default: state_d = S_OFF;
            endcase
        end

        if (start_char) begin
            sub_d = '0;
            idx_d = '0;
            etu_d = cyclePerEtu;
            inv_d = useIndirectConvention;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q     <= S_OFF;
            sub_q       <= '0;
            idx_q       <= '0;
            etu_q       <= '0;
            inv_q       <= 1'b0;
            atr_cnt_q   <= '0;
            atr_ready_q <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_byte_q   <= '0;
            retry_q     <= '0;
            rx_sh_q     <= '0;
            data_out_q  <= '0;
            drive_q     <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_perr_q   <= 1'b0;
            tx_error_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sub_q       <= sub_d;
            idx_q       <= idx_d;
            etu_q       <= etu_d;
            inv_q       <= inv_d;
            atr_cnt_q   <= atr_cnt_d;
            atr_ready_q <= atr_ready_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_byte_q   <= tx_byte_d;
            retry_q     <= retry_d;
            rx_sh_q     <= rx_sh_d;
            data_out_q  <= data_out_d;
            drive_q     <= drive_d;
            rx_valid_q  <= rx_valid_d;
            rx_perr_q   <= rx_perr_d;
            tx_error_q  <= tx_error_d;
        end
    end

    assign isoSio        = drive_q ? 1'b0 : 1'bz;
    assign dataOut       = data_out_q;
    assign rxValid       = rx_valid_q;
    assign rxParityError = rx_perr_q;
    assign txError       = tx_error_q;
    assign atrReady      = atr_ready_q;
    assign txReady       = atr_ready_q & ~hold_full_q;
    assign cardActive    = powered;

endmodule
